// File: rtl/dsp_chiplet_pkg.sv
// Shared types and defaults for the chiplet DSP receive path.
package dsp_chiplet_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 12;
    localparam int unsigned FFT_N          = 16;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2
    } rx_state_t;

    // |re|+|im| at the default width; |-2^(W-1)| is exact as an unsigned W-bit value.
    function automatic logic [DEF_DATA_WIDTH:0] l1_mag(
        input logic signed [DEF_DATA_WIDTH-1:0] re,
        input logic signed [DEF_DATA_WIDTH-1:0] im
    );
        logic [DEF_DATA_WIDTH-1:0] a;
        logic [DEF_DATA_WIDTH-1:0] b;
        a = re[DEF_DATA_WIDTH-1] ? -re : re;
        b = im[DEF_DATA_WIDTH-1] ? -im : im;
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/cplx_abs_l1.sv
// Combinational L1 magnitude |re|+|im| of a signed complex sample.
module cplx_abs_l1 #(
    parameter int unsigned W = 12
) (
    input  logic signed [W-1:0] i_re,
    input  logic signed [W-1:0] i_im,
    output logic        [W:0]   o_mag
);

    logic [W-1:0] w_abs_re;
    logic [W-1:0] w_abs_im;

    // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign w_abs_re = i_re[W-1] ? -i_re : i_re;
    assign w_abs_im = i_im[W-1] ? -i_im : i_im;
    assign o_mag    = {1'b0, w_abs_re} + {1'b0, w_abs_im};

endmodule

// File: rtl/dma_rx_collector.sv
// Collects one DMA frame of complex samples, tracks the L1 peak and holds the
// frame for the host read port until released.
module dma_rx_collector #(
    parameter int unsigned DATA_WIDTH = dsp_chiplet_pkg::DEF_DATA_WIDTH,
    parameter int unsigned N          = dsp_chiplet_pkg::FFT_N,
    parameter int unsigned AW         = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dma_valid,
    input  logic signed [DATA_WIDTH-1:0] dma_real,
    input  logic signed [DATA_WIDTH-1:0] dma_imag,
    input  logic                         done,
    input  logic                         stall,
    input  logic                         frame_release,
    input  logic        [AW-1:0]         rd_addr,
    output logic                         dma_ack,
    output logic        [DATA_WIDTH-1:0] rd_real,
    output logic        [DATA_WIDTH-1:0] rd_imag,
    output logic                         frame_ready,
    output logic        [AW:0]           frame_count,
    output logic        [DATA_WIDTH:0]   peak_mag,
    output logic        [AW-1:0]         peak_idx,
    output logic                         short_frame
);
    import dsp_chiplet_pkg::*;

    rx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_mem_re [N];
    logic [DATA_WIDTH-1:0] r_mem_im [N];
    logic [DATA_WIDTH-1:0] r_rd_re;
    logic [DATA_WIDTH-1:0] r_rd_im;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH:0]   r_peak_mag;
    logic [AW-1:0]         r_peak_idx;
    logic                  r_ready;
    logic                  r_short;

    logic                  w_xfer;
    logic [AW:0]           w_count_next;
    logic [AW-1:0]         w_wr_idx;
    logic [DATA_WIDTH:0]   w_mag;

    cplx_abs_l1 #(.W(DATA_WIDTH)) u_abs (
        .i_re  (dma_real),
        .i_im  (dma_imag),
        .o_mag (w_mag)
    );

    assign dma_ack      = (r_state == RECV) && !stall && reset;
    assign w_xfer       = dma_valid && dma_ack;
    assign w_count_next = r_count + {{AW{1'b0}}, w_xfer};
    assign w_wr_idx     = r_count[AW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= RECV;
            r_count    <= '0;
            r_peak_mag <= '0;
            r_peak_idx <= '0;
            r_ready    <= 1'b0;
            r_short    <= 1'b0;
            r_rd_re    <= '0;
            r_rd_im    <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_mem_re[i] <= '0;
                r_mem_im[i] <= '0;
            end
        end else begin
            r_rd_re <= r_mem_re[rd_addr];
            r_rd_im <= r_mem_im[rd_addr];
            unique case (r_state)
                RECV: begin
                    if (w_xfer) begin
                        r_mem_re[w_wr_idx] <= dma_real;
                        r_mem_im[w_wr_idx] <= dma_imag;
                        r_count            <= w_count_next;
                        // First sample of a frame always seeds the peak; later ties keep the earlier index.
                        if (r_count == '0 || w_mag > r_peak_mag) begin
                            r_peak_mag <= w_mag;
                            r_peak_idx <= w_wr_idx;
                        end
                    end
                    if (w_count_next == (AW+1)'(N)) begin
                        r_state <= HOLD;
                        r_ready <= 1'b1;
                    end else if (done && w_count_next != '0) begin
                        r_state <= HOLD;
                        r_ready <= 1'b1;
                        r_short <= 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_release) r_state <= CLEAR;
                end
                CLEAR: begin
                    r_count    <= '0;
                    r_peak_mag <= '0;
                    r_peak_idx <= '0;
                    r_ready    <= 1'b0;
                    r_state    <= RECV;
                end
                default: r_state <= RECV;
            endcase
        end
    end

    assign rd_real     = r_rd_re;
    assign rd_imag     = r_rd_im;
    assign frame_ready = r_ready;
    assign frame_count = r_count;
    assign peak_mag    = r_peak_mag;
    assign peak_idx    = r_peak_idx;
    assign short_frame = r_short;

endmodule
